// File: rtl/mix_vga_gain_sequencer_pkg.sv
// Shared definitions for the VGA gain sequencer: FSM encodings, default
// timing constants and the one-hot switch decoder.
package mix_vga_gain_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAKE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int DEF_SETTLE_CYC = 64;
  localparam int DEF_HOLD_CYC   = 800;
  localparam int MAX_SW         = 256;

  // Wide decoder; callers truncate to their own switch count (gain codes up to 8 bits).
  function automatic logic [MAX_SW-1:0] onehot(input logic [7:0] code);
    onehot       = '0;
    onehot[code] = 1'b1;
  endfunction

endpackage

// File: rtl/mix_vga_gain_sequencer_timer.sv
// Load / decrement / zero-flag counter shared by the SETTLE and HOLD windows.
module mix_vga_gain_sequencer_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != W'(1'b0))) begin
      cnt_d = cnt_q - W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= W'(1'b0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == W'(1'b0));

endmodule

// File: rtl/mix_vga_gain_sequencer.sv
// VGA resistor-switch sequencer: walks gain_applied one step at a time toward
// gain_req with make-before-break switching, a settle window and a dwell time.
module mix_vga_gain_sequencer
  import mix_vga_gain_sequencer_pkg::*;
#(
  parameter int GAIN_W     = 3,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  localparam int NSW       = 2 ** GAIN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GAIN_W-1:0] gain_req,
  input  logic              freeze,
  output logic [NSW-1:0]    vga_sw,
  output logic [GAIN_W-1:0] gain_applied,
  output logic              settling,
  output logic              step_done,
  output logic              at_target
);

  localparam int MAX_CYC = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYC - 1);

  state_e              state_q,     state_d;
  logic [GAIN_W-1:0]   gain_q,      gain_d;
  logic [GAIN_W-1:0]   target_q,    target_d;
  logic [NSW-1:0]      sw_q,        sw_d;
  logic                settling_q,  settling_d;
  logic                step_done_q, step_done_d;

  logic                tmr_load_s;
  logic [TW-1:0]       tmr_val_s;
  logic                tmr_dec_s;
  logic                tmr_zero_s;
  logic [GAIN_W-1:0]   step_s;

  mix_vga_gain_sequencer_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .dec_i      (tmr_dec_s),
    .zero_o     (tmr_zero_s)
  );

  // Neighbour code one step toward the request; only used when they differ.
  always_comb begin
    if (gain_req > gain_q) begin
      step_s = gain_q + GAIN_W'(1'b1);
    end else begin
      step_s = gain_q - GAIN_W'(1'b1);
    end
  end

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    target_d    = target_q;
    sw_d        = sw_q;
    settling_d  = 1'b0;
    step_done_d = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_val_s   = TW'(1'b0);
    tmr_dec_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!freeze && (gain_req != gain_q)) begin
          target_d   = step_s;
          sw_d       = NSW'(onehot(8'(gain_q))) | NSW'(onehot(8'(step_s)));
          settling_d = 1'b1;
          state_d    = ST_MAKE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAKE: begin
        gain_d     = target_q;
        sw_d       = NSW'(onehot(8'(target_q)));
        tmr_load_s = 1'b1;
        tmr_val_s  = SETTLE_LD;
        settling_d = 1'b1;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_zero_s) begin
          step_done_d = 1'b1;
          tmr_load_s  = 1'b1;
          tmr_val_s   = HOLD_LD;
          state_d     = ST_HOLD;
        end else begin
          tmr_dec_s  = 1'b1;
          settling_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_zero_s) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gain_q      <= GAIN_W'(1'b0);
      target_q    <= GAIN_W'(1'b0);
      sw_q        <= NSW'(1'b1);
      settling_q  <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      target_q    <= target_d;
      sw_q        <= sw_d;
      settling_q  <= settling_d;
      step_done_q <= step_done_d;
    end
  end

  assign vga_sw       = sw_q;
  assign gain_applied = gain_q;
  assign settling     = settling_q;
  assign step_done    = step_done_q;
  assign at_target    = (state_q == ST_IDLE) && (gain_req == gain_q);

endmodule
